// File: rtl/plic_mt.sv
// Multi-target PLIC: per-source level/edge gateways, per-target priority arbitration,
// and atomic claim/complete on a single-cycle peripheral bus with registered response.
module plic_mt #(
  parameter int SOURCES = 31,
  parameter int TARGETS = 2,
  parameter int PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  input  logic [SOURCES-1:0] irq_sources_i,
  output logic [SOURCES-1:0] irq_pending_o,
  output logic [TARGETS-1:0] irq_o
);

  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_INSVC} gw_e;

  gw_e                gw_q    [SOURCES];
  gw_e                gw_d    [SOURCES];
  logic [PRIO_W-1:0]  prio_q  [SOURCES];
  logic [SOURCES-1:0] en_q    [TARGETS];
  logic [PRIO_W-1:0]  thr_q   [TARGETS];
  logic [4:0]         win_id  [TARGETS];
  logic [SOURCES-1:0] mode_q, rearm_q, rearm_d, copy_q;
  logic [SOURCES-1:0] edge_vec, mode_chg, claim_vec, cmpl_vec, pend_vec;
  logic [TARGETS-1:0] irq_q;
  logic [31:0]        rd_mux;

  // Address decode on the 22 significant bits
  logic       wr, rd;
  logic [9:0] prio_id;
  logic [4:0] en_t;
  logic [8:0] tgt_t;
  logic       sel_prio, sel_pend, sel_mode, sel_en, sel_tgt;

  assign wr       = req_i & we_i & (be_i == 4'hF);
  assign rd       = req_i & ~we_i;
  assign prio_id  = addr_i[11:2];
  assign en_t     = addr_i[11:7];
  assign tgt_t    = addr_i[20:12];
  assign sel_prio = (addr_i[21:12] == 10'd0);
  assign sel_pend = (addr_i[21:2] == 20'h00400);
  assign sel_mode = (addr_i[21:2] == 20'h00420);
  assign sel_en   = (addr_i[21:12] == 10'd2) && (addr_i[6:2] == 5'd0);
  assign sel_tgt  = addr_i[21] && (addr_i[11:3] == 9'd0);

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:22], addr_i[1:0]};

  function automatic logic [31:0] src_word(input logic [SOURCES-1:0] v);
    logic [31:0] w;
    w = '0;
    w[SOURCES:1] = v;
    return w;
  endfunction

  assign edge_vec = mode_q & irq_sources_i & ~copy_q;
  assign mode_chg = (wr && sel_mode) ? (wdata_i[SOURCES:1] ^ mode_q) : '0;

  always_comb begin
    pend_vec = '0;
    for (int s = 0; s < SOURCES; s++) pend_vec[s] = (gw_q[s] == GW_PEND);
  end
  assign irq_pending_o = pend_vec;

  // Strictly-greater compare from the threshold keeps the lowest ID on ties
  always_comb begin : win_sel
    logic [PRIO_W-1:0] best_p;
    best_p = '0;
    for (int t = 0; t < TARGETS; t++) begin
      best_p    = thr_q[t];
      win_id[t] = 5'd0;
      for (int s = 0; s < SOURCES; s++) begin
        if (pend_vec[s] && en_q[t][s] && (prio_q[s] > best_p)) begin
          best_p    = prio_q[s];
          win_id[t] = 5'(s + 1);
        end
      end
    end
  end

  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int t = 0; t < TARGETS; t++) begin
      if (sel_tgt && addr_i[2] && (tgt_t == 9'(t))) begin
        for (int s = 0; s < SOURCES; s++) begin
          if (rd && (win_id[t] == 5'(s + 1))) claim_vec[s] = 1'b1;
          if (wr && (wdata_i == 32'(s + 1)) && en_q[t][s] && (gw_q[s] == GW_INSVC))
            cmpl_vec[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rearm_d = rearm_q;
    for (int s = 0; s < SOURCES; s++) begin
      gw_d[s] = gw_q[s];
      unique case (gw_q[s])
        GW_IDLE: begin
          if (mode_q[s] ? edge_vec[s] : irq_sources_i[s]) gw_d[s] = GW_PEND;
        end
        GW_PEND: begin
          if (claim_vec[s]) begin
            gw_d[s] = GW_INSVC;
            if (edge_vec[s]) rearm_d[s] = 1'b1;
          end
        end
        GW_INSVC: begin
          if (cmpl_vec[s]) begin
            gw_d[s]    = (rearm_q[s] || edge_vec[s]) ? GW_PEND : GW_IDLE;
            rearm_d[s] = 1'b0;
          end else if (edge_vec[s]) begin
            rearm_d[s] = 1'b1;
          end
        end
        default: gw_d[s] = GW_IDLE;
      endcase
      if (mode_chg[s]) rearm_d[s] = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_prio) begin
      for (int s = 0; s < SOURCES; s++)
        if (prio_id == 10'(s + 1)) rd_mux = 32'(prio_q[s]);
    end else if (sel_pend) begin
      rd_mux = src_word(pend_vec);
    end else if (sel_mode) begin
      rd_mux = src_word(mode_q);
    end else if (sel_en) begin
      for (int t = 0; t < TARGETS; t++)
        if (en_t == 5'(t)) rd_mux = src_word(en_q[t]);
    end else if (sel_tgt) begin
      for (int t = 0; t < TARGETS; t++)
        if (tgt_t == 9'(t)) rd_mux = addr_i[2] ? 32'(win_id[t]) : 32'(thr_q[t]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SOURCES; s++) begin
        gw_q[s]   <= GW_IDLE;
        prio_q[s] <= '0;
      end
      for (int t = 0; t < TARGETS; t++) begin
        en_q[t]  <= '0;
        thr_q[t] <= '0;
      end
      mode_q   <= '0;
      rearm_q  <= '0;
      copy_q   <= '0;
      irq_q    <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      for (int s = 0; s < SOURCES; s++) begin
        gw_q[s] <= gw_d[s];
        if (wr && sel_prio && (prio_id == 10'(s + 1))) prio_q[s] <= wdata_i[PRIO_W-1:0];
      end
      for (int t = 0; t < TARGETS; t++) begin
        if (wr && sel_en && (en_t == 5'(t))) en_q[t] <= wdata_i[SOURCES:1];
        if (wr && sel_tgt && !addr_i[2] && (tgt_t == 9'(t))) thr_q[t] <= wdata_i[PRIO_W-1:0];
        irq_q[t] <= (win_id[t] != 5'd0);
      end
      if (wr && sel_mode) mode_q <= wdata_i[SOURCES:1];
      rearm_q  <= rearm_d;
      copy_q   <= irq_sources_i;
      rvalid_o <= req_i;
      rdata_o  <= rd ? rd_mux : 32'd0;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_plic_mt.sv
// Scoreboarded bench for plic_mt: bus responses checked in order, interrupt lines checked by cycle.
module tb_plic_mt;
  localparam int SOURCES = 31;
  localparam int TARGETS = 2;
  localparam int PRIO_W  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req = 1'b0;
  logic [31:0]        addr = '0;
  logic               we = 1'b0;
  logic [3:0]         be = 4'hF;
  logic [31:0]        wdata = '0;
  logic               rvalid;
  logic [31:0]        rdata;
  logic [SOURCES-1:0] src = '0;
  logic [SOURCES-1:0] pend;
  logic [TARGETS-1:0] irq;

  plic_mt #(.SOURCES(SOURCES), .TARGETS(TARGETS), .PRIO_W(PRIO_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .irq_sources_i(src),
    .irq_pending_o(pend), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("rvalid_without_request", 32'(rvalid), 32'd0);
      else check(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] a_prio(input int id); return 32'(4 * id); endfunction
  function automatic logic [31:0] a_en(input int t);    return 32'h2000 + 32'(t * 'h80); endfunction
  function automatic logic [31:0] a_thr(input int t);   return 32'h200000 + 32'(t * 'h1000); endfunction
  function automatic logic [31:0] a_clm(input int t);   return a_thr(t) + 32'd4; endfunction
  localparam logic [31:0] A_PEND = 32'h1000;
  localparam logic [31:0] A_MODE = 32'h1080;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    req = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    exp_q.push_back(32'd0); tag_q.push_back("write_rdata_zero");
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'hF;
  endtask

  task automatic pulse(input int idx);
    src[idx] = 1'b1; tick(1);
    src[idx] = 1'b0; tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_pending", 32'(pend), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick(1);
    rd(a_prio(4), 32'd0, "reset_prio");

    // Level source 3 (ID 4)
    wr(a_prio(4), 32'd5);
    wr(a_en(0), 32'h10);
    src[3] = 1'b1;
    check("lvl_irq_n0", 32'(irq[0]), 32'd0);
    tick(1);
    check("lvl_pend_n1", 32'(pend[3]), 32'd1);
    check("lvl_irq_n1", 32'(irq[0]), 32'd0);
    tick(1);
    check("lvl_irq_n2", 32'(irq[0]), 32'd1);
    rd(a_clm(0), 32'd4, "lvl_claim");
    check("lvl_irq_claim_n1", 32'(irq[0]), 32'd1);
    tick(1);
    check("lvl_irq_claim_n2", 32'(irq[0]), 32'd0);
    wr(a_clm(0), 32'd4);
    tick(1);
    check("lvl_irq_cmpl_n2", 32'(irq[0]), 32'd0);
    tick(1);
    check("lvl_irq_repend", 32'(irq[0]), 32'd1);
    src[3] = 1'b0;
    rd(a_clm(0), 32'd4, "lvl_claim2");
    wr(a_clm(0), 32'd4);
    rd(A_PEND, 32'd0, "lvl_pend_clear");

    // Priority and tie order: IDs 2,7 prio 3; ID 5 prio 6
    wr(a_prio(2), 32'd3);
    wr(a_prio(7), 32'd3);
    wr(a_prio(5), 32'd6);
    wr(a_en(0), 32'hA4);
    src[1] = 1'b1; src[6] = 1'b1; src[4] = 1'b1;
    tick(1);
    src[1] = 1'b0; src[6] = 1'b0; src[4] = 1'b0;
    tick(1);
    check("prio_irq", 32'(irq[0]), 32'd1);
    rd(A_PEND, 32'hA4, "prio_pend_word");
    rd(a_clm(0), 32'd5, "prio_claim_1st");
    rd(a_clm(0), 32'd2, "prio_claim_2nd");
    rd(a_clm(0), 32'd7, "prio_claim_3rd");
    rd(a_clm(0), 32'd0, "prio_claim_none");
    wr(a_clm(0), 32'd5); wr(a_clm(0), 32'd2); wr(a_clm(0), 32'd7);
    wr(a_thr(0), 32'd6);
    src[1] = 1'b1; src[6] = 1'b1; src[4] = 1'b1;
    tick(1);
    src[1] = 1'b0; src[6] = 1'b0; src[4] = 1'b0;
    tick(3);
    check("thr6_irq_low", 32'(irq[0]), 32'd0);
    rd(a_clm(0), 32'd0, "thr6_claim");
    rd(a_thr(0), 32'd6, "thr_readback");
    wr(a_thr(0), 32'd5);
    rd(a_clm(0), 32'd5, "thr5_claim");
    wr(a_thr(0), 32'd0);
    rd(a_clm(0), 32'd2, "thr0_claim_a");
    rd(a_clm(0), 32'd7, "thr0_claim_b");
    wr(a_clm(0), 32'd5); wr(a_clm(0), 32'd2); wr(a_clm(0), 32'd7);

    // Edge source 0 (ID 1)
    wr(a_en(0), 32'h2);
    wr(a_prio(1), 32'd2);
    wr(A_MODE, 32'h2);
    rd(A_MODE, 32'h2, "edge_mode_readback");
    pulse(0);
    pulse(0);
    rd(A_PEND, 32'h2, "edge_pend");
    rd(a_clm(0), 32'd1, "edge_claim");
    rd(a_clm(0), 32'd0, "edge_coalesced");
    pulse(0);
    rd(A_PEND, 32'h0, "edge_insvc_not_pend");
    wr(a_clm(0), 32'd1);
    rd(A_PEND, 32'h2, "edge_rearm_pend");
    rd(a_clm(0), 32'd1, "edge_rearm_claim");
    rd(a_clm(0), 32'd0, "edge_rearm_empty");
    wr(a_clm(0), 32'd1);
    rd(A_PEND, 32'h0, "edge_idle");

    // Multi-target: ID 9 only on target 1
    wr(a_en(0), 32'h0);
    wr(a_prio(9), 32'd4);
    wr(a_en(1), 32'h200);
    src[8] = 1'b1; tick(1); src[8] = 1'b0; tick(1);
    check("mt_irq_t1", 32'(irq), 32'h2);
    rd(a_clm(0), 32'd0, "mt_claim_t0");
    rd(a_clm(1), 32'd9, "mt_claim_t1");
    wr(a_clm(0), 32'd9);
    src[8] = 1'b1;
    tick(3);
    check("mt_stays_insvc_irq", 32'(irq), 32'h0);
    rd(A_PEND, 32'h0, "mt_stays_insvc_pend");
    wr(a_clm(1), 32'd9);
    tick(2);
    check("mt_complete_t1", 32'(irq), 32'h2);

    // Bus corners
    wr(a_prio(9), 32'd7, 4'h3);
    rd(a_prio(9), 32'd4, "bus_partial_be");
    wr(a_prio(0), 32'd7);
    rd(a_prio(0), 32'd0, "bus_prio_id0");
    rd(a_prio(32), 32'd0, "bus_prio_id32");
    wr(a_thr(2), 32'd3);
    rd(a_thr(2), 32'd0, "bus_thr_t2");
    rd(a_en(2), 32'd0, "bus_en_t2");
    rd(a_clm(2), 32'd0, "bus_clm_t2");
    wr(a_thr(1), 32'd2);
    rd(a_thr(1), 32'd2, "bus_thr_t1");
    rd(32'h3000, 32'd0, "bus_unmapped");

    // Reset in the middle of a read request
    tick(2);
    req = 1'b1; we = 1'b0; addr = a_prio(9);
    #2 rst_n = 1'b0; src = '0;
    @(posedge clk); #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pending", 32'(pend), 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("rst_rvalid_after", 32'(rvalid), 32'd0);
    check("rst_irq_after", 32'(irq), 32'd0);
    rd(a_prio(9), 32'd0, "rst_prio_cleared");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/plic_mt.md
# plic_mt

Multi-target platform-level interrupt controller, parametrised successor to the single-target PLIC in the demo system. It gateways up to 31 interrupt sources (level or edge mode per source), arbitrates by priority per target with per-target enable and threshold, and implements atomic claim/complete with in-service tracking. It sits on the peripheral bus beside the timer/UART, and each bit of `irq_o` drives one hart's external-interrupt input.

## Interface
- `SOURCES`, default 31: number of sources, legal range 1..31. Source `i` (`irq_sources_i[i]`) has ID `i+1`. ID 0 means "no interrupt".
- `TARGETS`, default 2: number of interrupt targets, legal range 1..8.
- `PRIO_W`, default 3: priority/threshold width. Priority 0 means never interrupt.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  bus request, single-cycle, always accepted.
- `addr_i`  in  32  byte address; only `[21:0]` is decoded.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables. Writes take effect only when `be_i == 4'hF`.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid, one cycle after `req_i`.
- `rdata_o`  out  32  registered read data. 0 for writes and for unmapped addresses.
- `irq_sources_i`  in  SOURCES  synchronous interrupt inputs.
- `irq_pending_o`  out  SOURCES  gateway pending bits.
- `irq_o`  out  TARGETS  per-target interrupt request.

## Operation
- Register map (word offsets; bit `i+1` of a source word corresponds to source `i`; bit 0 reads 0):
  - `0x000000 + 4*ID`: priority, RW, `PRIO_W` bits. ID 0 and IDs above `SOURCES` read 0 and ignore writes.
  - `0x001000`: pending, RO.
  - `0x001080`: mode, RW. 1 = edge, 0 = level.
  - `0x002000 + 0x80*t`: enable word for target `t`, RW.
  - `0x200000 + 0x1000*t`: threshold for target `t`, RW.
  - `0x200004 + 0x1000*t`: claim on read, complete on write.
  - Any target index `t >= TARGETS` is unmapped.
- Gateway per source has three states: IDLE, PEND, INSVC.
  - Level mode: IDLE→PEND when the input is 1. The input is ignored in PEND and in INSVC.
  - Edge mode: a rising edge is detected against a registered copy of the input (copy resets to 0).
    - IDLE→PEND on an edge.
    - An edge in PEND is coalesced (dropped).
    - An edge in INSVC sets a one-deep `rearm` flag.
- Candidate for target `t`: the source is in PEND, `enable[t]` bit is set, and priority > threshold[t].
  - The winner is the highest priority; ties go to the lowest ID.
- Claim read for target `t` returns the winner's ID, or 0 if there is none. In the same cycle the winner moves PEND→INSVC.
  - A claim returning 0 has no side effect.
- Complete write of ID `n` to target `t` acts only when source `n` is in INSVC and `enable[t]` bit `n` is set; otherwise it is ignored.
  - On a valid complete, the source goes INSVC→IDLE, or INSVC→PEND if `rearm` is set (which clears `rearm`). A level source whose input is still 1 re-pends on the following cycle.
- Changing a mode bit does not alter the current gateway state. It clears `rearm` and the edge copy is reloaded.
- `irq_pending_o[i]` = (source `i` in PEND).

## Timing
- Reset values: all priorities, enables, thresholds and modes are 0; all gateways IDLE; `rearm` = 0; edge copies = 0; `rvalid_o` = 0; `rdata_o` = 0; `irq_pending_o` = 0; `irq_o` = 0.
- Bus: `rvalid_o` and `rdata_o` are valid in cycle N+1 for a request in cycle N.
  - Read data is sampled from state at cycle N, so a claim's side effect is not visible to that read.
  - Writes update registers at the edge ending cycle N.
- Input to pending: an input rising in cycle N makes the gateway PEND at N+1.
- Pending to interrupt: `irq_o` is registered, so `irq_o[t]` = 1 at N+2.
- Claim at cycle N: `irq_o[t]` reflects the removal at N+2.
- Simultaneous events:
  - A claim and a gateway event on the same source in the same cycle: the claim wins. A level re-assert is ignored; an edge sets `rearm`.
  - A valid complete and an edge on the same source in the same cycle: the source goes to PEND.
- Asynchronous reset mid-transaction drops the response: `rvalid_o` is 0 on the first cycle after release.

## Test plan
- Level source 3 (ID 4), priority 5, target 0 enabled, threshold 0, input held 1.
  - Required: `irq_o[0]` = 1 two cycles after the input rises.
  - Claim @`0x200004` returns 4 and `irq_o[0]` falls.
  - Complete with 4 while the input is still 1 re-asserts `irq_o[0]`.
- Priority and tie order: IDs 2 and 7 at priority 3, ID 5 at priority 6, all pending and enabled.
  - Required: successive claims return 5, then 2, then 7, then 0.
  - Raising threshold[0] to 6 holds `irq_o[0]` at 0.
- Edge source 0 (ID 1): two pulses while PEND give one claim.
  - Required: a pulse while INSVC sets `rearm`; completing 1 makes it pending again; the next claim returns 1, then 0.
- Multi-target: ID 9 enabled only for target 1.
  - Required: `irq_o` = 2'b10.
  - A claim on target 0 returns 0.
  - A complete of 9 on target 0 is ignored, so the source stays INSVC.
  - A complete on target 1 succeeds.
- Bus corners:
  - A write with `be_i` = 4'h3 leaves the register unchanged.
  - A read of priority ID 0, of ID > `SOURCES`, or of target index ≥ `TARGETS` returns 0.
  - Asserting `rst_ni` low during a pending request gives `rvalid_o` = 0 and every output at its reset value.
